// File: rtl/beeb_ext_bus_pkg.sv
// rtl/beeb_ext_bus_pkg.sv - shared constants and types for the external 6502 bus engine
package beeb_bus_pkg;

    localparam logic [15:0] IDLE_ADDR      = 16'hFFFF;
    localparam logic [7:0]  IDLE_DATA      = 8'hFF;
    localparam logic [15:0] DEF_SLOW_ADDR  = 16'hFE40;
    localparam int          DEF_SLOW_LONG  = 15;
    localparam int          DEF_SLOW_SHORT = 1;

    typedef enum logic [1:0] {IDLE, RD, WR} bus_kind_t;

endpackage

// File: rtl/beeb_ext_bus_if.sv
// rtl/beeb_ext_bus_if.sv - core-side request/ack handshake of the external bus engine
interface beeb_ext_bus_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();

    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output ack, rdata
    );

endinterface

// File: rtl/beeb_ext_bus_wbuf.sv
// rtl/beeb_ext_bus_wbuf.sv - posted-write FIFO holding {addr,data} entries
module beeb_wbuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/beeb_ext_bus.sv
// rtl/beeb_ext_bus.sv - PhiIn-synchronised external 6502 bus cycle engine with posted writes
module beeb_ext_bus
    import beeb_bus_pkg::*;
#(
    parameter int                NPHI0_REGS    = 5,
    parameter int                PHIOUT_TAP    = 1,
    parameter int                ADDR_W        = 16,
    parameter int                DATA_W        = 8,
    parameter int                WBUF_DEPTH    = 4,
    parameter int                POSTED_WRITES = 1,
    parameter logic [ADDR_W-1:0] SLOW_ADDR     = DEF_SLOW_ADDR,
    parameter int                SLOW_LONG     = DEF_SLOW_LONG,
    parameter int                SLOW_SHORT    = DEF_SLOW_SHORT
) (
    input  logic              clock,
    input  logic              Res_n,
    beeb_ext_bus_if.slave     core,
    output logic              wbuf_empty,
    output logic              slow,
    input  logic              PhiIn,
    output logic              Phi1Out,
    output logic              Phi2Out,
    output logic [ADDR_W-1:0] Addr,
    output logic              R_W_n,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe
);

    localparam bit          POSTED = (POSTED_WRITES != 0);
    localparam int          CW     = $clog2(WBUF_DEPTH) + 1;
    localparam logic [7:0]  LONG_C  = 8'(SLOW_LONG);
    localparam logic [7:0]  SHORT_C = 8'(SLOW_SHORT);

    logic [NPHI0_REGS-1:0] chain;
    logic                  cycle_end;
    logic                  cycle_start;

    bus_kind_t             kind;
    bus_kind_t             kind_nx;
    logic                  pop;
    logic                  push;
    logic                  accept;
    logic                  acc_rd;
    logic                  busy;
    logic                  rd_pending;
    logic [ADDR_W-1:0]     rd_addr;
    logic [7:0]            slow_cnt;

    logic [ADDR_W+DATA_W-1:0] wb_head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     wb_full;
    logic                     wb_empty;
    logic [CW-1:0]            wb_count;

    always_ff @(posedge clock or negedge Res_n) begin
        if (!Res_n) begin
            chain       <= '0;
            cycle_start <= 1'b0;
        end else begin
            chain       <= {chain[NPHI0_REGS-2:0], PhiIn};
            cycle_start <= cycle_end;
        end
    end

    assign cycle_end = chain[NPHI0_REGS-1] & ~chain[NPHI0_REGS-2];
    assign Phi2Out   = chain[PHIOUT_TAP];
    assign Phi1Out   = ~chain[PHIOUT_TAP];

    // busy covers a read or unposted write awaiting its completion ack.
    assign accept = core.req & ~core.ack & ~busy;
    assign push   = accept & core.req_we & ~wb_full;
    assign acc_rd = accept & ~core.req_we;

    beeb_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_wbuf (
        .clk       (clock),
        .rst_n     (Res_n),
        .push      (push),
        .push_data ({core.req_addr, core.req_wdata}),
        .pop       (pop),
        .head      (wb_head),
        .full      (wb_full),
        .empty     (wb_empty),
        .count     (wb_count)
    );

    assign {head_addr, head_data} = wb_head;

    always_ff @(posedge clock or negedge Res_n) begin
        if (!Res_n) kind <= IDLE;
        else        kind <= kind_nx;
    end

    // Buffered writes always win, so a read can only go out once every earlier write has.
    always_comb begin
        kind_nx = kind;
        pop     = 1'b0;
        if (cycle_start) begin
            if (wb_count != '0) begin
                kind_nx = WR;
                pop     = 1'b1;
            end else if (rd_pending) begin
                kind_nx = RD;
            end else begin
                kind_nx = IDLE;
            end
        end else if (cycle_end) begin
            kind_nx = IDLE;
        end
    end

    always_ff @(posedge clock or negedge Res_n) begin
        if (!Res_n) begin
            Addr       <= '1;
            R_W_n      <= 1'b1;
            Data_out   <= '1;
            core.ack   <= 1'b0;
            core.rdata <= '0;
            busy       <= 1'b0;
            rd_pending <= 1'b0;
            rd_addr    <= '0;
            slow_cnt   <= '0;
        end else begin
            core.ack <= 1'b0;
            if (acc_rd) begin
                busy       <= 1'b1;
                rd_pending <= 1'b1;
                rd_addr    <= core.req_addr;
            end
            if (push) begin
                if (POSTED) core.ack <= 1'b1;
                else        busy     <= 1'b1;
            end

            if (cycle_start) begin
                if (kind_nx == WR) begin
                    Addr     <= head_addr;
                    Data_out <= head_data;
                    R_W_n    <= 1'b0;
                end else if (kind_nx == RD) begin
                    Addr       <= rd_addr;
                    Data_out   <= '1;
                    R_W_n      <= 1'b1;
                    rd_pending <= 1'b0;
                end else begin
                    Addr     <= '1;
                    Data_out <= '1;
                    R_W_n    <= 1'b1;
                end
            end

            if (cycle_end) begin
                if (kind == RD) begin
                    core.rdata <= Data_in;
                    core.ack   <= 1'b1;
                    busy       <= 1'b0;
                end else if (kind == WR && !POSTED && busy && wb_count == '0) begin
                    core.ack <= 1'b1;
                    busy     <= 1'b0;
                end

                if (kind == WR && Addr == SLOW_ADDR)
                    slow_cnt <= (Data_out[2:0] == 3'd0) ? LONG_C : SHORT_C;
                else if (slow_cnt != '0)
                    slow_cnt <= slow_cnt - 1'b1;
            end
        end
    end

    assign wbuf_empty = wb_empty & (kind != WR);
    assign slow       = (slow_cnt != '0);
    assign Data_oe    = ~R_W_n & PhiIn;

endmodule

// File: doc/beeb_ext_bus.md
Name: beeb_ext_bus

Overview:
Parametrised external 6502 bus cycle engine. It sits between the fast internal CPU core and the Beeb motherboard bus. It synchronises PhiIn and sequences one external transaction per 2 MHz/1 MHz bus cycle. New in this generation: a posted-write buffer, so the core continues while writes drain; generalised sync-chain, width and slowdown parameters; and strict read-after-write ordering.

Parameters:
NPHI0_REGS, 5, length of PhiIn synchroniser/delay chain (>=3)
PHIOUT_TAP, 1, chain tap driving Phi2Out/Phi1Out
ADDR_W, 16, address width
DATA_W, 8, data width
WBUF_DEPTH, 4, posted-write buffer entries (power of 2, >=2)
POSTED_WRITES, 1, 1=ack writes on buffer entry; 0=ack at bus cycle end
SLOW_ADDR, 16'hFE40, address whose writes trigger forced slowdown
SLOW_LONG, 15, slowdown bus cycles when written data[2:0]==0
SLOW_SHORT, 1, slowdown bus cycles otherwise

Ports:
clock  in  1  single clock for all logic (cpu_clk domain)
Res_n  in  1  asynchronous active-low reset
req  in  1  core request; held with fields stable until ack
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
ack  out  1  one-cycle completion pulse
rdata  out  DATA_W  read data; valid with ack on reads, held until next read
wbuf_empty  out  1  no buffered or in-flight writes
slow  out  1  forced-slowdown active (core gates internal clken)
PhiIn  in  1  asynchronous motherboard Phi0
Phi1Out  out  1  !chain[PHIOUT_TAP]
Phi2Out  out  1  chain[PHIOUT_TAP]
Addr  out  ADDR_W  bus address
R_W_n  out  1  bus read/write, 1=read
Data_in  in  DATA_W  bus data from pad
Data_out  out  DATA_W  bus write data
Data_oe  out  1  pad drive enable = bus_we & PhiIn (combinational)

Behaviour:
- Reset (async, Res_n=0): chain=0, Addr=all-ones, R_W_n=1, Data_out=all-ones, ack=0, rdata=0, buffer flushed (wbuf_empty=1), slowdown count=0, no cycle in flight. Reset mid-transaction discards pending writes and requests.
- cycle_end = chain[N-1] & !chain[N-2]; cycle_start = cycle_end delayed one clock. All bus outputs change only on cycle_start; this gives address hold.
- Request accept rule: req & !ack.
  - Write, POSTED_WRITES=1, buffer not full: push {addr,data}; ack the next clock.
  - Write, buffer full: stall until a pop frees an entry.
- On cycle_start, in priority order:
  - Buffer non-empty: pop the head and drive it (R_W_n=0).
  - Else read pending: drive it (R_W_n=1).
  - Else idle: Addr all-ones, R_W_n=1, Data_out all-ones.
- Reads issue only when the buffer is empty and no write is in flight. This gives strict ordering, including a read of the address just written.
- On cycle_end with a read in flight: rdata<=Data_in, ack pulse on the next clock. Data_in is sampled in the clock domain; there is no Phi2 negedge flop.
- POSTED_WRITES=0: write enters the buffer but acks at the cycle_end completing that write.
- Push and pop on the same cycle_start: occupancy unchanged. Pointers wrap modulo WBUF_DEPTH. full = count==WBUF_DEPTH.
- Slowdown count register, updated on cycle_end:
  - Completing write to SLOW_ADDR: load SLOW_LONG if data[2:0]==0, else SLOW_SHORT.
  - Otherwise, if nonzero: decrement.
  - slow = count!=0. slow does not block this block's own sequencing.
- At most one ack per clock. ack is never asserted without an accepted request.

Decomposition:
- Package beeb_bus_pkg: IDLE_ADDR/IDLE_DATA constants; SLOW_ADDR, SLOW_LONG and SLOW_SHORT defaults; enum for bus cycle kind {IDLE, RD, WR}.
- Sub-module beeb_wbuf: parametrised synchronous FIFO (DEPTH, width ADDR_W+DATA_W) with push/pop, full, empty and count.
- Top holds the sync chain, sequencer, slowdown counter and ack logic.

Test Plan:
- Reset with PhiIn toggling at 2 MHz and clock 80 MHz -> Addr=16'hFFFF, R_W_n=1, ack=0 until a request; Phi2Out follows PhiIn after PHIOUT_TAP+1 clocks.
- Three back-to-back writes (3000->11,12,13) -> three acks within 1 clock each; bus shows writes 3000/11,12,13 on three consecutive bus cycles in order; wbuf_empty rises after the third cycle_end.
- Five writes with WBUF_DEPTH=4 -> fifth ack is delayed until the first pop at cycle_start; no entry lost or reordered.
- Write FE60<-55 then read FE60, Data_in=AA -> read appears on the bus only after the write cycle; rdata=AA with ack one clock after that cycle_end.
- Write FE40<-08 -> slow=1 for exactly 15 cycle_ends. Write FE40<-0B -> slow=1 for 1 cycle_end. Non-FE40 write during slowdown does not reload the count.
- Assert Res_n=0 mid-drain with 2 entries buffered -> outputs go to idle immediately; after release no buffered write reaches the bus.
